// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch unit (optional perf counters: FETCH_PERF_CNT_EN)
package fetch_unit_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [31:0] raw_instr;
    } fetch_data_t;

endpackage

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output fetch_data_t dataF,
    output logic [63:0] fetch_cnt,
    output logic [63:0] discard_cnt
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_HOLD    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [63:0] pc, pc_n;
    logic [63:0] req_addr, req_addr_n;
    fetch_data_t data_q, data_n;
    logic        fetch_hit;
    logic        drop_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_FETCH;
            pc       <= PC_RESET;
            req_addr <= PC_RESET;
            data_q   <= '0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            req_addr <= req_addr_n;
            data_q   <= data_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        req_addr_n = req_addr;
        data_n     = data_q;
        fetch_hit  = 1'b0;
        drop_hit   = 1'b0;
        case (state)
            S_FETCH: begin
                if (redirect_valid) begin
                    if (iresp_data_ok) begin
                        // response and redirect coincide: drop it and refetch at the target
                        req_addr_n = redirect_pc;
                        drop_hit   = 1'b1;
                    end else begin
                        // request stays on the bus until its response drains
                        pc_n    = redirect_pc;
                        state_n = S_DISCARD;
                    end
                end else if (iresp_data_ok) begin
                    data_n.valid     = 1'b1;
                    data_n.pc        = req_addr;
                    data_n.raw_instr = iresp_data;
                    pc_n             = req_addr + 64'd4;
                    state_n          = S_HOLD;
                    fetch_hit        = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    data_n.valid = 1'b0;
                    req_addr_n   = redirect_pc;
                    state_n      = S_FETCH;
                end else if (!stall) begin
                    data_n.valid = 1'b0;
                    req_addr_n   = pc;
                    state_n      = S_FETCH;
                end
            end
            S_DISCARD: begin
                if (iresp_data_ok) begin
                    // a redirect landing with the stale response is the newest target
                    req_addr_n = redirect_valid ? redirect_pc : pc;
                    drop_hit   = 1'b1;
                    state_n    = S_FETCH;
                end else if (redirect_valid) begin
                    pc_n = redirect_pc;
                end
            end
            default: begin
                state_n = S_FETCH;
            end
        endcase
    end

    assign ireq_valid = (state != S_HOLD);
    assign ireq_addr  = req_addr;
    assign dataF      = data_q;

`ifdef FETCH_PERF_CNT_EN
    logic [63:0] fetch_cnt_q;
    logic [63:0] discard_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt_q   <= '0;
            discard_cnt_q <= '0;
        end else begin
            if (fetch_hit) fetch_cnt_q <= fetch_cnt_q + 64'd1;
            if (drop_hit)  discard_cnt_q <= discard_cnt_q + 64'd1;
        end
    end

    assign fetch_cnt   = fetch_cnt_q;
    assign discard_cnt = discard_cnt_q;
`else
    logic unused_hits;
    assign unused_hits = fetch_hit ^ drop_hit;
    assign fetch_cnt   = '0;
    assign discard_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized checks of fetch_unit against a program-order model
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [63:0] PC_RESET = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok = 1'b0;
    logic [31:0] iresp_data = '0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    fetch_data_t dataF;
    logic [63:0] fetch_cnt;
    logic [63:0] discard_cnt;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [63:0] exp_pc;
    longint      deliveries;
    longint      responses;
    int          wait_n;

    always #5 clk = ~clk;

    fetch_unit #(.PC_RESET(PC_RESET)) dut (
        .clk(clk),
        .reset(reset),
        .ireq_valid(ireq_valid),
        .ireq_addr(ireq_addr),
        .iresp_data_ok(iresp_data_ok),
        .iresp_data(iresp_data),
        .stall(stall),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .dataF(dataF),
        .fetch_cnt(fetch_cnt),
        .discard_cnt(discard_cnt)
    );

    function automatic logic [31:0] instr_at(input logic [63:0] a);
        return a[31:0] ^ {a[63:32] + 32'h1357_9bdf};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input bit ok, input logic [31:0] d, input bit st, input bit rv,
                       input logic [63:0] rp);
        iresp_data_ok  = ok;
        iresp_data     = d;
        stall          = st;
        redirect_valid = rv;
        redirect_pc    = rp;
        @(negedge clk);
    endtask

    task automatic check_cnt(input string tag, input longint f, input longint dsc);
`ifdef FETCH_PERF_CNT_EN
        check({tag, "_fetch_cnt"}, fetch_cnt, 64'(f));
        check({tag, "_discard_cnt"}, discard_cnt, 64'(dsc));
`else
        check({tag, "_fetch_cnt_off"}, fetch_cnt, 64'd0);
        check({tag, "_discard_cnt_off"}, discard_cnt, 64'd0);
`endif
    endtask

    task automatic rand_cycle(input bit quiet);
        fetch_data_t pd;
        logic        piv;
        logic [63:0] pa;
        bit          ok, st, rv, rose;
        logic [63:0] rp;
        pd  = dataF;
        piv = ireq_valid;
        pa  = ireq_addr;
        ok  = 1'b0;
        st  = !quiet && ($urandom_range(0, 2) == 0);
        rv  = !quiet && ($urandom_range(0, 7) == 0);
        rp  = ($urandom_range(0, 9) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC
                                          : {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_0FFC)};
        if (!quiet && piv) begin
            if (wait_n == 0) begin
                ok     = 1'b1;
                wait_n = $urandom_range(0, 3);
            end else begin
                wait_n--;
            end
        end
        if (ok) responses++;
        cyc(ok, instr_at(pa), st, rv, rp);
        check("req_data_exclusive", 64'(ireq_valid & dataF.valid), 64'd0);
        if (piv && !ok) begin
            check("addr_hold", ireq_addr, pa);
            check("req_hold", 64'(ireq_valid), 64'd1);
        end
        if (pd.valid && st && !rv) begin
            check("stall_valid", 64'(dataF.valid), 64'd1);
            check("stall_pc", dataF.pc, pd.pc);
            check("stall_raw", 64'(dataF.raw_instr), 64'(pd.raw_instr));
        end
        rose = dataF.valid && !pd.valid;
        if (rv) begin
            check("redirect_no_delivery", 64'(rose), 64'd0);
            exp_pc = rp;
        end else if (rose) begin
            check("deliver_pc", dataF.pc, exp_pc);
            check("deliver_raw", 64'(dataF.raw_instr), 64'(instr_at(exp_pc)));
            exp_pc = exp_pc + 64'd4;
            deliveries++;
        end
    endtask

    initial begin
        #1 reset = 1'b1;
        #1;
        check("rst_ireq_valid", 64'(ireq_valid), 64'd1);
        check("rst_ireq_addr", ireq_addr, PC_RESET);
        check("rst_valid", 64'(dataF.valid), 64'd0);
        check("rst_pc", dataF.pc, 64'd0);
        check("rst_raw", 64'(dataF.raw_instr), 64'd0);
        check_cnt("rst", 0, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // first fetch, response two cycles late, then a three-cycle stall
        cyc(0, 32'h0, 0, 0, 64'h0);
        check("f0_addr", ireq_addr, 64'h8000_0000);
        check("f0_req", 64'(ireq_valid), 64'd1);
        cyc(0, 32'h0, 0, 0, 64'h0);
        cyc(1, 32'h0000_0013, 0, 0, 64'h0);
        check("f0_valid", 64'(dataF.valid), 64'd1);
        check("f0_pc", dataF.pc, 64'h8000_0000);
        check("f0_raw", 64'(dataF.raw_instr), 64'h13);
        check("f0_noreq", 64'(ireq_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 32'h0, 1, 0, 64'h0);
            check("stall3_valid", 64'(dataF.valid), 64'd1);
            check("stall3_pc", dataF.pc, 64'h8000_0000);
            check("stall3_noreq", 64'(ireq_valid), 64'd0);
        end
        cyc(0, 32'h0, 0, 0, 64'h0);
        check("f1_addr", ireq_addr, 64'h8000_0004);
        check("f1_valid0", 64'(dataF.valid), 64'd0);
        cyc(1, 32'h1111_1111, 0, 0, 64'h0);
        check("f1_pc", dataF.pc, 64'h8000_0004);
        cyc(0, 32'h0, 0, 0, 64'h0);
        check("f2_addr", ireq_addr, 64'h8000_0008);

        // redirect while the request to ...08 is pending
        cyc(0, 32'h0, 0, 1, 64'h8000_0100);
        check("disc_addr_hold", ireq_addr, 64'h8000_0008);
        check("disc_req", 64'(ireq_valid), 64'd1);
        cyc(0, 32'h0, 0, 0, 64'h0);
        check("disc_addr_hold2", ireq_addr, 64'h8000_0008);
        check("disc_valid0", 64'(dataF.valid), 64'd0);
        cyc(1, 32'h2222_2222, 0, 0, 64'h0);
        check("disc_next_addr", ireq_addr, 64'h8000_0100);
        check("disc_dropped", 64'(dataF.valid), 64'd0);

        // redirect and response in the same cycle
        cyc(1, 32'h3333_3333, 0, 1, 64'h8000_0200);
        check("same_cyc_valid0", 64'(dataF.valid), 64'd0);
        check("same_cyc_addr", ireq_addr, 64'h8000_0200);
        cyc(1, 32'h4444_4444, 0, 0, 64'h0);
        check("f3_pc", dataF.pc, 64'h8000_0200);

        // redirect beats stall in hold
        cyc(0, 32'h0, 1, 1, 64'h8000_0300);
        check("hold_redir_valid0", 64'(dataF.valid), 64'd0);
        check("hold_redir_addr", ireq_addr, 64'h8000_0300);
        check("hold_redir_req", 64'(ireq_valid), 64'd1);
        cyc(1, 32'h5555_5555, 0, 0, 64'h0);
        cyc(0, 32'h0, 0, 0, 64'h0);
        check("f5_addr", ireq_addr, 64'h8000_0304);
        cyc(1, 32'h6666_6666, 0, 0, 64'h0);
        check("f5_pc", dataF.pc, 64'h8000_0304);
        check_cnt("directed", 5, 2);

        // randomized traffic against the program-order model
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_pc     = PC_RESET;
        deliveries = 0;
        responses  = 0;
        wait_n     = 0;
        for (int i = 0; i < 3000; i++) rand_cycle(1'b0);
        rand_cycle(1'b1);
        rand_cycle(1'b1);
        check("rand_progress", 64'(deliveries > 100), 64'd1);
        check_cnt("rand", deliveries, responses - deliveries);

        // reset abandons an outstanding request
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cyc(1, 32'h0, 0, 1, 64'h1234_5600);
        cyc(0, 32'h0, 0, 0, 64'h0);
        check("mid_req_addr", ireq_addr, 64'h1234_5600);
        #2 reset = 1'b1;
        #1;
        check("async_rst_addr", ireq_addr, PC_RESET);
        check("async_rst_valid", 64'(dataF.valid), 64'd0);
        check("async_rst_pc", dataF.pc, 64'd0);
        check_cnt("async_rst", 0, 0);
        iresp_data_ok = 1'b1;
        @(negedge clk);
        iresp_data_ok = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_addr", ireq_addr, PC_RESET);
        check("post_rst_valid0", 64'(dataF.valid), 64'd0);
        cyc(1, 32'h0000_00AB, 0, 0, 64'h0);
        check("post_rst_pc", dataF.pc, PC_RESET);
        check("post_rst_raw", 64'(dataF.raw_instr), 64'hAB);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_RESET, default 64'h0000_0000_8000_0000, the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port ireq_valid, output, 1, instruction-bus request valid.
REQ-005 SHALL have port ireq_addr, output, 64, instruction-bus request address.
REQ-006 SHALL have port iresp_data_ok, input, 1, the response for the outstanding request is present this cycle.
REQ-007 SHALL have port iresp_data, input, 32, instruction word, sampled only when iresp_data_ok=1.
REQ-008 SHALL have port stall, input, 1, decode cannot accept dataF this cycle.
REQ-009 SHALL have port redirect_valid, input, 1, control-flow redirect request.
REQ-010 SHALL have port redirect_pc, input, 64, redirect target.
REQ-011 SHALL have port dataF, output, fetch_data_t, registered fields valid(1), pc(64), raw_instr(32) presented to decode.
REQ-012 SHALL have ports fetch_cnt and discard_cnt, output, 64 each, performance counters (see Configuration).

Function
REQ-013 SHALL implement FSM states S_FETCH, S_HOLD and S_DISCARD, plus registers pc (next fetch address) and req_addr (outstanding request address).
REQ-014 S_FETCH: ireq_valid=1, ireq_addr=req_addr; ireq_addr SHALL stay stable until iresp_data_ok.
REQ-015 S_FETCH, iresp_data_ok=1, redirect_valid=0: next cycle dataF={1, req_addr, iresp_data}; pc<=req_addr+4 (mod 2^64); state->S_HOLD.
REQ-016 S_HOLD: ireq_valid=0; dataF held unchanged while stall=1.
REQ-017 S_HOLD, stall=0: the instruction is consumed; next cycle dataF.valid=0, req_addr<=pc, state->S_FETCH.
REQ-018 Redirect in S_FETCH with iresp_data_ok=0: pc<=redirect_pc, state->S_DISCARD, request held at the old req_addr.
REQ-019 Redirect in S_FETCH with iresp_data_ok=1 in the same cycle: response dropped, dataF.valid stays 0, req_addr<=redirect_pc, state stays S_FETCH.
REQ-020 Redirect in S_HOLD: dataF.valid<=0, req_addr<=redirect_pc, state->S_FETCH; redirect SHALL take priority over stall.
REQ-021 S_DISCARD: ireq_valid=1, ireq_addr=old req_addr; on iresp_data_ok the data SHALL be dropped, req_addr<=pc, state->S_FETCH.
REQ-022 Redirect in S_DISCARD: pc<=redirect_pc (latest wins), state stays S_DISCARD.
REQ-023 dataF.valid SHALL never be 1 in S_FETCH or S_DISCARD.
REQ-024 At most one bus request SHALL be outstanding; no new address is issued before iresp_data_ok for the current one.

Reset
REQ-025 On reset assertion, regardless of clock: state=S_FETCH, pc=PC_RESET, req_addr=PC_RESET, dataF.valid=0, dataF.pc=0, dataF.raw_instr=0, counters=0.
REQ-026 Reset mid-request SHALL abandon any outstanding response; the first request after release SHALL use address PC_RESET.

Configuration
REQ-027 With macro FETCH_PERF_CNT_EN defined: fetch_cnt SHALL increment on each REQ-015 transition; discard_cnt SHALL increment on each response dropped under REQ-019 or REQ-021; both wrap mod 2^64.
REQ-028 Without FETCH_PERF_CNT_EN: both ports SHALL be driven constant 0 and no counter registers synthesized; all other behaviour unchanged.

Verification
REQ-029 Release reset; bus answers 2 cycles later with 32'h00000013 -> ireq_addr=64'h80000000, then dataF={1, 64'h80000000, 32'h00000013}, next request at 64'h80000004.
REQ-030 stall=1 for 3 cycles while in S_HOLD -> dataF constant, ireq_valid=0; stall drops -> next request at pc+4.
REQ-031 Redirect to 64'h80000100 while request to 64'h80000008 is pending -> ireq_addr holds 64'h80000008 until data_ok, data dropped, next request 64'h80000100, dataF.valid never 1 for 64'h80000008.
REQ-032 redirect_valid and iresp_data_ok in the same cycle -> no dataF.valid, next ireq_addr=redirect_pc.
REQ-033 Redirect with stall=1 in S_HOLD -> dataF.valid=0 next cycle, fetch resumes at redirect_pc.
REQ-034 FETCH_PERF_CNT_EN defined, 5 fetches and 2 discards -> fetch_cnt=5, discard_cnt=2; undefined -> both 0.
